// File: rtl/egress_port_shaper.sv
// Per-port egress stage: framing check, FWFT buffer, optional store-and-forward, inter-packet gap.
// Latency: head word is visible on the tx side one cycle after it is written (SAF waits for the Eop write).
// Backpressure: oRdRdy drops only when the buffer is full; iTxRdy low holds the head word stable.

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module egress_port_shaper #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter bit SAF        = 1'b1,
  parameter int IPG_W      = 4
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iRdSop,
  input  logic                  iRdEop,
  input  logic                  iRdVld,
  input  logic [DATA_WIDTH-1:0] iRdData,
  output logic                  oRdRdy,
  input  logic                  iRdLast,
  output logic                  oTxSop,
  output logic                  oTxEop,
  output logic                  oTxVld,
  output logic [DATA_WIDTH-1:0] oTxData,
  input  logic                  iTxRdy,
  input  logic [IPG_W-1:0]      iIpgCycles,
  output logic [31:0]           oPktCnt,
  output logic [15:0]           oErrCnt,
  output logic [15:0]           oBurstCnt,
  output logic                  oBusy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_WIDTH + 2;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic {WAIT_SOP, IN_PKT} inState_t;
  typedef enum logic [1:0] {IDLE, SEND, GAP} txState_t;

  logic [ENT_W-1:0]      fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wrPtr, rdPtr;
  logic [CNT_W-1:0]      fifoCnt, pktInFifo;
  inState_t              inState;
  txState_t              txState;
  logic [IPG_W-1:0]      gapCnt;

  logic                  fifoEmpty, fifoFull, rdAccept, fifoWr, fifoRd, frameErr;
  logic                  wrEop, txVld, txEopHs, canStart;
  logic [ENT_W-1:0]      headEnt;
  logic                  headSop, headEop;
  logic [DATA_WIDTH-1:0] headData;

  assign fifoEmpty = (fifoCnt == '0);
  assign fifoFull  = (fifoCnt == DEPTH_C);
  assign oRdRdy    = iRst_n && !fifoFull;
  assign rdAccept  = iRdVld && oRdRdy;
  // A word is kept unless it arrives between packets without a Sop.
  assign fifoWr    = rdAccept && (inState == IN_PKT || iRdSop);
  assign frameErr  = rdAccept && ((inState == WAIT_SOP && !iRdSop) || (inState == IN_PKT && iRdSop));
  assign wrEop     = fifoWr && iRdEop;

  assign headEnt   = fifoMem[rdPtr];
  assign headSop   = headEnt[ENT_W-1];
  assign headEop   = headEnt[ENT_W-2];
  assign headData  = headEnt[DATA_WIDTH-1:0];

  // Full buffer also releases a packet so one longer than the FIFO cannot deadlock.
  assign canStart  = !fifoEmpty && (!SAF || pktInFifo != '0 || fifoFull);

  // Tx valid follows the FSM and the head entry in the same cycle.
  always_comb begin
    txVld = 1'b0;
    if (iRst_n) begin
      case (txState)
        IDLE:    txVld = canStart;
        SEND:    txVld = !fifoEmpty;
        default: txVld = 1'b0;
      endcase
    end
  end

  assign fifoRd  = txVld && iTxRdy;
  assign txEopHs = fifoRd && headEop;

  assign oTxVld  = txVld;
  assign oTxSop  = txVld && headSop;
  assign oTxEop  = txVld && headEop;
  assign oTxData = txVld ? headData : '0;
  assign oBusy   = !fifoEmpty || txState != IDLE;

  // Buffer storage; stale entries are unreachable once the pointers are reset.
  always_ff @(posedge iClk) begin
    if (fifoWr) fifoMem[wrPtr] <= {iRdSop, iRdEop, iRdData};
  end

  // Pointers, occupancy and count of complete packets held.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCnt   <= '0;
      pktInFifo <= '0;
    end else begin
      if (fifoWr) wrPtr <= wrPtr + PTR_W'(1);
      if (fifoRd) rdPtr <= rdPtr + PTR_W'(1);
      case ({fifoWr, fifoRd})
        2'b10:   fifoCnt <= fifoCnt + CNT_W'(1);
        2'b01:   fifoCnt <= fifoCnt - CNT_W'(1);
        default: fifoCnt <= fifoCnt;
      endcase
      case ({wrEop, txEopHs})
        2'b10:   pktInFifo <= pktInFifo + CNT_W'(1);
        2'b01:   pktInFifo <= pktInFifo - CNT_W'(1);
        default: pktInFifo <= pktInFifo;
      endcase
    end
  end

  // Input framing tracker; a stray Sop mid-packet simply starts a new packet.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      inState <= WAIT_SOP;
    end else if (fifoWr) begin
      inState <= iRdEop ? WAIT_SOP : IN_PKT;
    end
  end

  // Tx sequencing: start, stream, then hold off for the programmed gap.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      txState <= IDLE;
      gapCnt  <= '0;
    end else if (txEopHs) begin
      gapCnt  <= iIpgCycles;
      txState <= (iIpgCycles != '0) ? GAP : IDLE;
    end else begin
      case (txState)
        IDLE: if (txVld) txState <= SEND;
        SEND: txState <= SEND;
        GAP: begin
          if (gapCnt <= IPG_W'(1)) txState <= IDLE;
          else gapCnt <= gapCnt - IPG_W'(1);
        end
        default: txState <= IDLE;
      endcase
    end
  end

  // Statistics: packets out (wrapping), framing errors (saturating), burst ends (wrapping).
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      oPktCnt   <= '0;
      oErrCnt   <= '0;
      oBurstCnt <= '0;
    end else begin
      if (txEopHs) oPktCnt <= oPktCnt + 32'd1;
      if (frameErr && oErrCnt != 16'hFFFF) oErrCnt <= oErrCnt + 16'd1;
      if (wrEop && iRdLast) oBurstCnt <= oBurstCnt + 16'd1;
    end
  end

endmodule
